// File: rtl/router_pkt_reg.sv
// Packet register stage between the router FSM and the output FIFOs.
// It forwards header and payload bytes, parks one byte while the FIFO is full, and checks the packet checksum and length.
module router_pkt_reg #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int LEN_W    = DATA_W - ADDR_W,
    parameter int CHK_MODE = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [LEN_W-1:0]  pay_cnt
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] int_chk;
    logic [DATA_W-1:0] pkt_chk;

    logic new_pkt, lfd_e, ld_e, laf_e;

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (CHK_MODE == 1) return a + b;
        else               return a ^ b;
    endfunction

    // State inputs should be one-hot; resolve any overlap by fixed priority.
    always_comb begin
        new_pkt = detect_add && pkt_valid;
        lfd_e   = lfd_state && !detect_add;
        ld_e    = ld_state && !detect_add && !lfd_state;
        laf_e   = laf_state && !detect_add && !lfd_state && !ld_state;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout    <= '0;
            header  <= '0;
            hold    <= '0;
            int_chk <= '0;
            pkt_chk <= '0;
            pay_cnt <= '0;
        end else if (new_pkt) begin
            header  <= data_in;
            int_chk <= '0;
            pay_cnt <= '0;
        end else if (lfd_e) begin
            dout    <= header;
            int_chk <= fold(int_chk, header);
        end else if (ld_e) begin
            if (!fifo_full) dout <= data_in;
            else            hold <= data_in;
            if (pkt_valid && !full_state) begin
                int_chk <= fold(int_chk, data_in);
                if (pay_cnt != CNT_MAX) pay_cnt <= pay_cnt + 1'b1;
            end
            // The trailing checksum byte is captured but never folded or counted.
            if (!pkt_valid) pkt_chk <= data_in;
        end else if (laf_e) begin
            dout <= hold;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            low_pkt_valid <= 1'b0;
        else if (rst_int_reg)
            low_pkt_valid <= 1'b0;
        else if (ld_e && !pkt_valid)
            low_pkt_valid <= 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
        end else if (new_pkt) begin
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            if ((ld_e && !pkt_valid && !fifo_full) ||
                (laf_e && low_pkt_valid && !parity_done))
                parity_done <= 1'b1;
            // Compare one edge after the checksum lands, then keep refreshing.
            if (parity_done) begin
                err     <= (int_chk != pkt_chk);
                len_err <= (pay_cnt != header[DATA_W-1:ADDR_W]);
            end
        end
    end

endmodule
